keypad_entry: RTL and testbench

Front end for the door lock: collects hex key presses from the keypad scanner, assembles them into the 8-bit code word, and presents it to the lock comparator with a clean enter strobe. It is the producer side of the lock's passin/enter interface. It also enforces inter-digit timeout, reports entry errors, and freezes entry while the lock is in alarm.

---
 rtl/keypad_entry.sv | 136 +++++++++++++
 tb/tb_keypad_entry.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/keypad_entry.sv
// Keypad front end for the door lock: assembles hex digits into a code word,
// issues the enter strobe, and handles clear, entry errors, inter-digit timeout and alarm freeze.
module keypad_entry #(
  parameter int unsigned NDIG    = 2,
  parameter int unsigned DIGW    = 4,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned PULSE_W = 2
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         key_dig,
  input  logic [DIGW-1:0]              key_code,
  input  logic                         key_ent,
  input  logic                         key_clr,
  input  logic                         alarm_in,
  output logic [NDIG*DIGW-1:0]         passin,
  output logic                         enter,
  output logic [$clog2(NDIG+1)-1:0]    digit_cnt,
  output logic                         key_err,
  output logic                         tmo
);

  localparam int unsigned PW  = NDIG * DIGW;
  localparam int unsigned CW  = $clog2(NDIG + 1);
  localparam int unsigned TW  = $clog2(TIMEOUT);
  localparam int unsigned PCW = $clog2(PULSE_W + 1);

  typedef enum logic {ST_COLLECT = 1'b0, ST_STROBE = 1'b1} state_t;

  state_t          r_state, w_state;
  logic [PW-1:0]   r_buf, w_buf;
  logic [CW-1:0]   r_cnt, w_cnt;
  logic [TW-1:0]   r_timer, w_timer;
  logic [PCW-1:0]  r_pcnt, w_pcnt;
  logic [PW-1:0]   r_passin, w_passin;
  logic            r_enter, w_enter;
  logic            r_err, w_err;
  logic            r_tmo, w_tmo;

  // State and every output live in flops; enter drives the lock as a clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state  <= ST_COLLECT;
      r_buf    <= '0;
      r_cnt    <= '0;
      r_timer  <= '0;
      r_pcnt   <= '0;
      r_passin <= '0;
      r_enter  <= 1'b0;
      r_err    <= 1'b0;
      r_tmo    <= 1'b0;
    end else begin
      r_state  <= w_state;
      r_buf    <= w_buf;
      r_cnt    <= w_cnt;
      r_timer  <= w_timer;
      r_pcnt   <= w_pcnt;
      r_passin <= w_passin;
      r_enter  <= w_enter;
      r_err    <= w_err;
      r_tmo    <= w_tmo;
    end
  end

  // Next state: key priority clr > ent > dig; a rejected digit holds the timer.
  always_comb begin
    w_state  = r_state;
    w_buf    = r_buf;
    w_cnt    = r_cnt;
    w_timer  = r_timer;
    w_pcnt   = r_pcnt;
    w_passin = r_passin;
    w_enter  = r_enter;
    w_err    = 1'b0;
    w_tmo    = 1'b0;
    case (r_state)
      ST_STROBE: begin
        if (r_pcnt == PCW'(PULSE_W - 1)) begin
          w_enter = 1'b0;
          w_pcnt  = '0;
          w_state = ST_COLLECT;
        end else begin
          w_pcnt = r_pcnt + 1'b1;
        end
      end
      ST_COLLECT: begin
        if (alarm_in) begin
          w_buf   = '0;
          w_cnt   = '0;
          w_timer = '0;
        end else if (key_clr) begin
          w_buf   = '0;
          w_cnt   = '0;
          w_timer = '0;
        end else if (key_ent) begin
          if (r_cnt == CW'(NDIG)) begin
            w_passin = r_buf;
            w_enter  = 1'b1;
            w_pcnt   = '0;
            w_state  = ST_STROBE;
          end else begin
            w_err = 1'b1;
          end
          w_buf   = '0;
          w_cnt   = '0;
          w_timer = '0;
        end else if (key_dig) begin
          if (r_cnt < CW'(NDIG)) begin
            w_buf   = {r_buf[PW-DIGW-1:0], key_code};
            w_cnt   = r_cnt + 1'b1;
            w_timer = '0;
          end else begin
            w_err = 1'b1;
          end
        end else if (r_cnt != '0) begin
          if (r_timer == TW'(TIMEOUT - 1)) begin
            w_buf   = '0;
            w_cnt   = '0;
            w_timer = '0;
            w_tmo   = 1'b1;
          end else begin
            w_timer = r_timer + 1'b1;
          end
        end
      end
      default: w_state = ST_COLLECT;
    endcase
  end

  assign passin    = r_passin;
  assign enter     = r_enter;
  assign digit_cnt = r_cnt;
  assign key_err   = r_err;
  assign tmo       = r_tmo;

endmodule

// File: tb/tb_keypad_entry.sv
// Directed bench for keypad_entry: a queue-based entry model checked every cycle,
// plus hand-computed literal expectations for each scenario.
module tb_keypad_entry;

  localparam int unsigned NDIG    = 2;
  localparam int unsigned DIGW    = 4;
  localparam int unsigned TIMEOUT = 8;
  localparam int unsigned PULSE_W = 2;

  logic       clk = 1'b0;
  logic       rstn;
  logic       key_dig, key_ent, key_clr, alarm_in;
  logic [3:0] key_code;
  logic [7:0] passin;
  logic       enter;
  logic [1:0] digit_cnt;
  logic       key_err, tmo;

  int checks = 0;
  int errors = 0;

  keypad_entry #(.NDIG(NDIG), .DIGW(DIGW), .TIMEOUT(TIMEOUT), .PULSE_W(PULSE_W)) dut (
    .clk(clk), .rstn(rstn), .key_dig(key_dig), .key_code(key_code),
    .key_ent(key_ent), .key_clr(key_clr), .alarm_in(alarm_in),
    .passin(passin), .enter(enter), .digit_cnt(digit_cnt),
    .key_err(key_err), .tmo(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Entry model: digits held in a queue, idle cycles counted since the last digit.
  int         q[$];
  int         m_idle, m_sl;
  logic [7:0] m_passin;
  bit         m_err, m_tmo;

  task automatic model_step();
    int v;
    if (!rstn) begin
      q.delete(); m_idle = 0; m_sl = 0; m_passin = '0; m_err = 0; m_tmo = 0;
      return;
    end
    m_err = 0; m_tmo = 0;
    if (m_sl > 0) m_sl--;
    else if (alarm_in) begin q.delete(); m_idle = 0; end
    else if (key_clr) begin q.delete(); m_idle = 0; end
    else if (key_ent) begin
      if (q.size() == NDIG) begin
        v = 0;
        foreach (q[i]) v = (v << DIGW) | q[i];
        m_passin = 8'(v);
        m_sl = PULSE_W;
      end else m_err = 1;
      q.delete(); m_idle = 0;
    end else if (key_dig) begin
      if (q.size() < NDIG) begin q.push_back(int'(key_code)); m_idle = 0; end
      else m_err = 1;
    end else if (q.size() > 0) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin q.delete(); m_idle = 0; m_tmo = 1; end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // Every-cycle compare against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("passin", passin, m_passin);
    chk("enter", enter, (m_sl > 0) ? 1 : 0);
    chk("digit_cnt", digit_cnt, q.size());
    chk("key_err", key_err, m_err);
    chk("tmo", tmo, m_tmo);
  end

  // Drive keys for one sampling edge; returns on the negedge after it.
  task automatic keys(input bit d, input bit e, input bit c, input logic [3:0] code);
    key_dig = d; key_ent = e; key_clr = c; key_code = code;
    @(negedge clk);
    key_dig = 0; key_ent = 0; key_clr = 0; key_code = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int s;
    rstn = 0; key_dig = 0; key_ent = 0; key_clr = 0; alarm_in = 0; key_code = '0;
    idle(3);
    chk("rst passin", passin, 0);
    chk("rst enter", enter, 0);
    chk("rst cnt", digit_cnt, 0);
    rstn = 1;
    idle(1);

    // 1: two digits then enter
    keys(1, 0, 0, 4'h6); chk("t1 cnt1", digit_cnt, 1);
    keys(1, 0, 0, 4'hA); chk("t1 cnt2", digit_cnt, 2);
    keys(0, 1, 0, 4'h0);
    chk("t1 enter", enter, 1); chk("t1 passin", passin, 8'h6A); chk("t1 cnt0", digit_cnt, 0);
    s = 1;
    repeat (3) begin @(negedge clk); s += int'(enter); end
    chk("t1 enter width", s, 2);

    // 2: short entry
    keys(1, 0, 0, 4'h3);
    keys(0, 1, 0, 4'h0);
    chk("t2 err", key_err, 1); chk("t2 enter", enter, 0);
    chk("t2 passin", passin, 8'h6A); chk("t2 cnt", digit_cnt, 0);

    // 3: overflow digit, buffer kept, then clr+ent error
    keys(1, 0, 0, 4'h1); keys(1, 0, 0, 4'h2); keys(1, 0, 0, 4'h3);
    chk("t3 err", key_err, 1); chk("t3 cnt", digit_cnt, 2);
    keys(0, 1, 0, 4'h0); chk("t3 passin", passin, 8'h12);
    idle(2);
    keys(1, 0, 0, 4'h1); keys(1, 0, 0, 4'h2);
    keys(0, 0, 1, 4'h0); chk("t3 clr cnt", digit_cnt, 0); chk("t3 clr err", key_err, 0);
    keys(0, 1, 0, 4'h0); chk("t3 ent err", key_err, 1); chk("t3 no strobe", enter, 0);

    // 4: timeout, then a digit on the timeout edge
    keys(1, 0, 0, 4'h5);
    s = 0;
    repeat (7) begin @(negedge clk); s += int'(tmo); end
    chk("t4 early tmo", s, 0);
    @(negedge clk);
    chk("t4 tmo", tmo, 1); chk("t4 cnt", digit_cnt, 0);
    keys(1, 0, 0, 4'h5);
    s = 0;
    repeat (7) begin @(negedge clk); s += int'(tmo); end
    keys(1, 0, 0, 4'h7); s += int'(tmo);
    chk("t4b tmo", s, 0); chk("t4b cnt", digit_cnt, 2);
    keys(0, 0, 1, 4'h0);

    // 5: simultaneous keys
    keys(1, 0, 0, 4'h7);
    keys(1, 1, 1, 4'hF);
    chk("t5 cnt", digit_cnt, 0); chk("t5 err", key_err, 0); chk("t5 enter", enter, 0);
    keys(1, 0, 0, 4'h8); keys(1, 0, 0, 4'h9);
    keys(1, 1, 0, 4'hF);
    chk("t5 strobe", enter, 1); chk("t5 passin", passin, 8'h89); chk("t5 cnt0", digit_cnt, 0);
    idle(3);

    // 6: alarm freeze, strobe completing under alarm, reset mid-strobe
    alarm_in = 1;
    keys(1, 0, 0, 4'h1); chk("t6 a cnt", digit_cnt, 0); chk("t6 a err", key_err, 0);
    keys(1, 0, 0, 4'h2); chk("t6 a cnt2", digit_cnt, 0);
    keys(0, 1, 0, 4'h0); chk("t6 a enter", enter, 0); chk("t6 a err2", key_err, 0);
    alarm_in = 0;
    keys(1, 0, 0, 4'h4); keys(1, 0, 0, 4'h5); keys(0, 1, 0, 4'h0);
    alarm_in = 1;
    idle(1); chk("t6 alarm strobe hi", enter, 1);
    idle(1); chk("t6 alarm strobe lo", enter, 0); chk("t6 passin45", passin, 8'h45);
    alarm_in = 0;
    keys(1, 0, 0, 4'hA); keys(1, 0, 0, 4'hB); keys(0, 1, 0, 4'h0);
    keys(1, 0, 0, 4'h3);
    chk("t6 strobe ignores key", digit_cnt, 0); chk("t6 strobe no err", key_err, 0);
    chk("t6 still strobing", enter, 1);
    #2 rstn = 0;
    #1;
    chk("t6 rst enter", enter, 0); chk("t6 rst passin", passin, 0); chk("t6 rst cnt", digit_cnt, 0);
    @(negedge clk);
    rstn = 1;
    idle(2);
    keys(1, 0, 0, 4'hC); chk("t6 post rst cnt", digit_cnt, 1);
    idle(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
